shl_pipe_ctrl: RTL and testbench

- Two-stage sequential issue/retire stage wrapped around the ALU's 8-bit combinational left-shift unit.
- Accepts shift requests on a valid/ready handshake and registers the operands that drive the shifter.
- Captures the shifter result together with carry and zero flags, and presents them on a valid/ready output with full backpressure.
- Sustains one operation per cycle; fixed latency of 2 cycles when the output is not stalled.

---
 rtl/shl_pipe_ctrl.sv | 111 +++++++++++
 tb/tb_shl_pipe_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shl_pipe_ctrl.sv
// shl_pipe_ctrl: two-stage issue/retire wrapper around the external 8-bit
// combinational left-shift unit.
//   S1 registers the request and drives the shift unit (shl_a/shl_shift).
//   S2 captures result, carry and zero and presents them with backpressure.
// Optional feature: define SHL_ROTATE_EN to honour in_rot (rotate left).
// Without it in_rot is ignored and no right-shift logic is built.
module shl_pipe_ctrl #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [SHW-1:0]   in_shift,
    input  logic             in_rot,
    output logic [WIDTH-1:0] shl_a,
    output logic [SHW-1:0]   shl_shift,
    input  logic [WIDTH-1:0] shl_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic [1:0]       inflight
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [SHW-1:0]   s1_shift;
    logic             s2_free;
    logic             s1_move;
    logic             in_fire;
    logic [SHW-1:0]   carry_idx;
    logic             nxt_carry;
    logic [WIDTH-1:0] nxt_result;

    // Handshake: S2 can take a new value when empty or being drained now.
    assign s2_free  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;
    assign s1_move  = s1_valid && s2_free;
    assign in_fire  = in_valid && in_ready;

    // Shift unit sees the S1 registers directly, stable for the whole cycle.
    assign shl_a     = s1_a;
    assign shl_shift = s1_shift;

    // Last bit shifted out is a[WIDTH - shift]; modulo-8 arithmetic gives
    // that index in 3 bits for shift 1..7, shift 0 has no carry.
    assign carry_idx = '0 - s1_shift;
    assign nxt_carry = (s1_shift == '0) ? 1'b0 : s1_a[carry_idx];

`ifdef SHL_ROTATE_EN
    logic             s1_rot;
    logic [SHW:0]     rot_rsh;

    // Rotate = shift-unit result OR'd with the bits that fell off the top;
    // shift 0 gives a right shift by 8, i.e. no fill, so the result is s1_a.
    assign rot_rsh    = (SHW+1)'(WIDTH) - {1'b0, s1_shift};
    assign nxt_result = s1_rot ? (shl_out | (s1_a >> rot_rsh)) : shl_out;

    // Rotate flag travels with the S1 operands.
    always_ff @(posedge clk) begin
        if (rst)
            s1_rot <= 1'b0;
        else if (in_fire)
            s1_rot <= in_rot;
    end
`else
    logic unused_rot;

    assign unused_rot = in_rot;
    assign nxt_result = shl_out;
`endif

    // S1: load on accept, otherwise empty out when moving into S2.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_shift <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_a     <= in_a;
            s1_shift <= in_shift;
        end else if (s1_move) begin
            s1_valid <= 1'b0;
        end
    end

    // S2: capture result and flags on move, drop valid on drain; data holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_carry  <= 1'b0;
            out_zero   <= 1'b0;
        end else if (s1_move) begin
            out_valid  <= 1'b1;
            out_result <= nxt_result;
            out_carry  <= nxt_carry;
            out_zero   <= (nxt_result == '0);
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    assign inflight = {1'b0, s1_valid} + {1'b0, out_valid};

endmodule

// File: tb/tb_shl_pipe_ctrl.sv
// Bench for shl_pipe_ctrl: vector table with latency checks, streaming,
// backpressure and mid-stream reset; a queue scoreboard checks every output.
// The shift unit itself is modelled here as a combinational a << shift.
module tb_shl_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [2:0] in_shift;
    logic       in_rot;
    logic [7:0] shl_a;
    logic [2:0] shl_shift;
    logic [7:0] shl_out;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic       out_carry;
    logic       out_zero;
    logic [1:0] inflight;

    shl_pipe_ctrl #(.WIDTH(8), .SHW(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_shift(in_shift), .in_rot(in_rot),
        .shl_a(shl_a), .shl_shift(shl_shift), .shl_out(shl_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_carry(out_carry), .out_zero(out_zero),
        .inflight(inflight)
    );

    always #5 clk = ~clk;

    assign shl_out = shl_a << shl_shift;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0] res;
        logic       carry;
        logic       zero;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t model(input logic [7:0] a, input logic [2:0] sh, input logic r);
        exp_t        e;
        logic [8:0]  w;
        logic [15:0] d;
        w = {1'b0, a} << sh;
        d = {a, a} << sh;
        e.res   = w[7:0];
        e.carry = w[8];
`ifdef SHL_ROTATE_EN
        if (r) e.res = d[15:8];
`else
        if (r) e.res = w[7:0];
`endif
        e.zero = (e.res == 8'h00);
        return e;
    endfunction

    // Scoreboard: sampled just before each rising edge, where the handshakes
    // that edge will see are already settled.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got result 0x%0h, expected no output", out_result);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_result", 32'(out_result), 32'(e.res));
                    chk("sb_carry", 32'(out_carry), 32'(e.carry));
                    chk("sb_zero", 32'(out_zero), 32'(e.zero));
                end
            end
            if (in_valid && in_ready)
                sb.push_back(model(in_a, in_shift, in_rot));
        end
    end

    typedef struct {
        logic [7:0] a;
        logic [2:0] sh;
        logic       rot;
        logic [7:0] res;
        logic       carry;
        logic       zero;
    } vec_t;

    vec_t vt[7];

    // Hold a request until accepted; returns on the falling edge after it.
    task automatic send(input logic [7:0] a, input logic [2:0] sh, input logic r);
        int n;
        in_valid = 1'b1;
        in_a     = a;
        in_shift = sh;
        in_rot   = r;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0, expected 1 within 50 cycles");
        end
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        #1;
        while ((sb.size() != 0 || inflight != 2'd0) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, 32'(sb.size()), 32'd0);
        chk({name, "_inflight"}, 32'(inflight), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1);
    end

    initial begin
        logic [11:0] ov;
        logic [7:0]  hold_res;

        vt[0] = '{8'h96, 3'd3, 1'b0, 8'hB0, 1'b0, 1'b0};
        vt[1] = '{8'h80, 3'd1, 1'b0, 8'h00, 1'b1, 1'b1};
        vt[2] = '{8'h5A, 3'd0, 1'b0, 8'h5A, 1'b0, 1'b0};
        vt[3] = '{8'h01, 3'd7, 1'b0, 8'h80, 1'b0, 1'b0};
        vt[4] = '{8'hC3, 3'd2, 1'b0, 8'h0C, 1'b1, 1'b0};
`ifdef SHL_ROTATE_EN
        vt[5] = '{8'h96, 3'd3, 1'b1, 8'hB4, 1'b0, 1'b0};
        vt[6] = '{8'hFF, 3'd7, 1'b1, 8'hFF, 1'b1, 1'b0};
`else
        vt[5] = '{8'h96, 3'd3, 1'b1, 8'hB0, 1'b0, 1'b0};
        vt[6] = '{8'hFF, 3'd7, 1'b1, 8'h80, 1'b1, 1'b0};
`endif

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_shift = '0; in_rot = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_shl_a", 32'(shl_a), 32'd0);
        chk("rst_shl_shift", 32'(shl_shift), 32'd0);
        chk("rst_out_result", 32'(out_result), 32'd0);
        chk("rst_out_flags", 32'({out_carry, out_zero}), 32'd0);
        @(negedge clk);

        // Single ops: result two cycles after the drive cycle, one-cycle pulse
        for (int i = 0; i < 7; i++) begin
            send(vt[i].a, vt[i].sh, vt[i].rot);
            in_valid = 1'b0;
            #1;
            chk("lat_early", 32'(out_valid), 32'd0);
            @(negedge clk);
            #1;
            chk("lat_valid", 32'(out_valid), 32'd1);
            chk("vec_result", 32'(out_result), 32'(vt[i].res));
            chk("vec_carry", 32'(out_carry), 32'(vt[i].carry));
            chk("vec_zero", 32'(out_zero), 32'(vt[i].zero));
            @(negedge clk);
            #1;
            chk("lat_pulse", 32'(out_valid), 32'd0);
            @(negedge clk);
        end

        // Back-to-back stream of shift 0..7 on 0xFF
        ov = '0;
        for (int k = 0; k < 12; k++) begin
            if (k < 8) begin
                in_valid = 1'b1; in_a = 8'hFF; in_shift = 3'(k); in_rot = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (k < 8) chk("stream_in_ready", 32'(in_ready), 32'd1);
            ov[k] = out_valid;
            @(negedge clk);
        end
        chk("stream_valid_run", 32'(ov), 32'h3FC);
        drain("stream_drain");

        // Backpressure: two accepts fill both stages, then everything holds
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 8'h11; in_shift = 3'd1; in_rot = 1'b0;
        #1;
        chk("bp_accept0", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_a = 8'h33; in_shift = 3'd2;
        #1;
        chk("bp_accept1", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_a = 8'h81; in_shift = 3'd4;
        hold_res = 8'h22;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_inflight", 32'(inflight), 32'd2);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_result", 32'(out_result), 32'(hold_res));
            chk("bp_hold_flags", 32'({out_carry, out_zero}), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        drain("bp_drain");

        // Reset with both stages full drops everything
        out_ready = 1'b0;
        send(8'h0F, 3'd1, 1'b0);
        send(8'hF0, 3'd2, 1'b0);
        in_valid = 1'b0;
        #1;
        chk("mrst_pre_inflight", 32'(inflight), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_inflight", 32'(inflight), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            chk("mrst_no_stale", 32'(out_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
